// File: rtl/jelly2_rtos_semaphore_pkg.sv
// Shared types for the RTOS counting semaphore and its wait queue.
package jelly2_rtos_semaphore_pkg;

    // Command opcodes presented by the RTOS command decoder
    typedef enum logic [1:0] {
        OP_SIG = 2'd0,
        OP_WAI = 2'd1,
        OP_POL = 2'd2,
        OP_CAN = 2'd3
    } sem_op_t;

    // Result codes returned for every accepted command
    typedef enum logic [1:0] {
        E_OK    = 2'd0,
        E_WAIT  = 2'd1,
        E_TMOUT = 2'd2,
        E_QOVR  = 2'd3
    } sem_res_t;

    // Command FSM: SETTLE covers the one-cycle queue update latency
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Returns 1 when priority value a is strictly more urgent than b
    // (smaller value wins; equal values keep arrival order).
    function automatic logic pri_higher(input logic [31:0] a, input logic [31:0] b);
        return (a < b);
    endfunction

endpackage

// File: rtl/jelly2_rtos_queue.sv
// Task wait queue: entries kept in arrival order, head selected either as the
// oldest entry (FIFO) or the most urgent priority (oldest among equals).
// All outputs are registered; they reflect an add/remove one cycle later.
module jelly2_rtos_queue
    import jelly2_rtos_semaphore_pkg::*;
#(
    parameter bit PRIORITY_ORDER = 1'b1,
    parameter int QUE_SIZE       = 16,
    parameter int ID_WIDTH       = 4,
    parameter int PRI_WIDTH      = 4,
    parameter int COUNT_WIDTH    = $clog2(QUE_SIZE + 1)
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [ID_WIDTH-1:0]    add_id,
    input  logic [PRI_WIDTH-1:0]   add_pri,
    input  logic                   add_valid,
    input  logic [ID_WIDTH-1:0]    remove_id,
    input  logic                   remove_valid,
    output logic [ID_WIDTH-1:0]    top_id,
    output logic                   top_valid,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] QUE_FULL = COUNT_WIDTH'(QUE_SIZE);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [ID_WIDTH-1:0]    id_q   [QUE_SIZE];
    logic [PRI_WIDTH-1:0]   pri_q  [QUE_SIZE];
    logic [ID_WIDTH-1:0]    id_d   [QUE_SIZE];
    logic [PRI_WIDTH-1:0]   pri_d  [QUE_SIZE];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [ID_WIDTH-1:0]    top_id_q;
    logic [ID_WIDTH-1:0]    top_id_d;
    logic                   top_valid_q;
    logic                   top_valid_d;
    logic                   hit_s;
    logic                   match_s;
    logic [COUNT_WIDTH-1:0] hit_idx_s;
    logic                   sel_s;
    logic [PRI_WIDTH-1:0]   best_pri_s;

    // Next queue contents (append or compacting remove) and next head entry
    always_comb begin
        id_d       = id_q;
        pri_d      = pri_q;
        count_d    = count_q;
        hit_s      = 1'b0;
        match_s    = 1'b0;
        hit_idx_s  = CNT_ZERO;
        sel_s      = 1'b0;
        if (add_valid && (count_q < QUE_FULL)) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                id_d[i]  = (COUNT_WIDTH'(i) == count_q) ? add_id  : id_q[i];
                pri_d[i] = (COUNT_WIDTH'(i) == count_q) ? add_pri : pri_q[i];
            end
            count_d = count_q + CNT_ONE;
        end else if (remove_valid) begin
            // first live entry carrying the requested ID
            for (int i = 0; i < QUE_SIZE; i++) begin
                match_s   = (COUNT_WIDTH'(i) < count_q) && (id_q[i] == remove_id);
                hit_idx_s = (!hit_s && match_s) ? COUNT_WIDTH'(i) : hit_idx_s;
                hit_s     = hit_s || match_s;
            end
            // close the gap so entries stay in arrival order
            for (int i = 0; i < QUE_SIZE - 1; i++) begin
                id_d[i]  = (hit_s && (COUNT_WIDTH'(i) >= hit_idx_s)) ? id_q[i+1]  : id_q[i];
                pri_d[i] = (hit_s && (COUNT_WIDTH'(i) >= hit_idx_s)) ? pri_q[i+1] : pri_q[i];
            end
            count_d = hit_s ? (count_q - CNT_ONE) : count_q;
        end else begin
            count_d = count_q;
        end

        top_valid_d = (count_d != CNT_ZERO);
        top_id_d    = id_d[0];
        best_pri_s  = pri_d[0];
        if (PRIORITY_ORDER) begin
            for (int i = 1; i < QUE_SIZE; i++) begin
                sel_s      = (COUNT_WIDTH'(i) < count_d) &&
                             pri_higher(32'(pri_d[i]), 32'(best_pri_s));
                top_id_d   = sel_s ? id_d[i]  : top_id_d;
                best_pri_s = sel_s ? pri_d[i] : best_pri_s;
            end
        end else begin
            top_id_d = id_d[0];
        end
    end

    // Queue state registers, frozen while cke is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                id_q[i]  <= {ID_WIDTH{1'b0}};
                pri_q[i] <= {PRI_WIDTH{1'b0}};
            end
            count_q     <= CNT_ZERO;
            top_id_q    <= {ID_WIDTH{1'b0}};
            top_valid_q <= 1'b0;
        end else if (cke) begin
            id_q        <= id_d;
            pri_q       <= pri_d;
            count_q     <= count_d;
            top_id_q    <= top_id_d;
            top_valid_q <= top_valid_d;
        end
    end

    assign top_id    = top_id_q;
    assign top_valid = top_valid_q;
    assign count     = count_q;

endmodule

// File: rtl/jelly2_rtos_semaphore.sv
// Hardware counting semaphore: keeps the count, parks blocked tasks in a wait
// queue and releases the queue head on a signal. Queue commands are
// registered, so any command that changes the queue is followed by one
// SETTLE cycle in which no new command is accepted.
module jelly2_rtos_semaphore
    import jelly2_rtos_semaphore_pkg::*;
#(
    parameter bit PRIORITY_ORDER = 1'b1,
    parameter int QUE_SIZE       = 16,
    parameter int ID_WIDTH       = 4,
    parameter int PRI_WIDTH      = 4,
    parameter int SEMCNT_WIDTH   = 8,
    parameter int INIT_COUNT     = 0,
    parameter int MAX_COUNT      = 2**SEMCNT_WIDTH - 1,
    parameter int QUECNT_WIDTH   = $clog2(QUE_SIZE + 1)
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cke,
    input  sem_op_t                 cmd_op,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [PRI_WIDTH-1:0]    cmd_pri,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output sem_res_t                res_code,
    output logic                    res_valid,
    output logic [ID_WIDTH-1:0]     wakeup_id,
    output logic                    wakeup_valid,
    output logic [SEMCNT_WIDTH-1:0] semcnt,
    output logic [QUECNT_WIDTH-1:0] wait_count
);

    localparam logic [SEMCNT_WIDTH-1:0] INIT_CNT = SEMCNT_WIDTH'(INIT_COUNT);
    localparam logic [SEMCNT_WIDTH-1:0] MAX_CNT  = SEMCNT_WIDTH'(MAX_COUNT);
    localparam logic [SEMCNT_WIDTH-1:0] SEM_ZERO = {SEMCNT_WIDTH{1'b0}};
    localparam logic [SEMCNT_WIDTH-1:0] SEM_ONE  = {{(SEMCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [QUECNT_WIDTH-1:0] QUE_FULL = QUECNT_WIDTH'(QUE_SIZE);
    localparam logic [QUECNT_WIDTH-1:0] QUE_ZERO = {QUECNT_WIDTH{1'b0}};

    state_t                  state_q,        state_d;
    logic [SEMCNT_WIDTH-1:0] semcnt_q,       semcnt_d;
    sem_res_t                res_code_q,     res_code_d;
    logic                    res_valid_q,    res_valid_d;
    logic [ID_WIDTH-1:0]     wakeup_id_q,    wakeup_id_d;
    logic                    wakeup_valid_q, wakeup_valid_d;
    logic [ID_WIDTH-1:0]     add_id_q,       add_id_d;
    logic [PRI_WIDTH-1:0]    add_pri_q,      add_pri_d;
    logic                    add_valid_q,    add_valid_d;
    logic [ID_WIDTH-1:0]     rm_id_q,        rm_id_d;
    logic                    rm_valid_q,     rm_valid_d;

    logic                    accept_s;
    logic                    que_reset_s;
    logic [ID_WIDTH-1:0]     que_top_id_s;
    logic                    que_top_valid_s;
    logic [QUECNT_WIDTH-1:0] que_count_s;
    logic                    has_waiter_s;

    assign accept_s     = cmd_valid && (state_q == ST_IDLE);
    assign que_reset_s  = ~reset_n;
    assign has_waiter_s = (que_count_s != QUE_ZERO) && que_top_valid_s;

    // Command decode: next counter, result, wakeup and queue request
    always_comb begin
        state_d        = ST_IDLE;
        semcnt_d       = semcnt_q;
        res_code_d     = res_code_q;
        res_valid_d    = 1'b0;
        wakeup_id_d    = wakeup_id_q;
        wakeup_valid_d = 1'b0;
        add_id_d       = add_id_q;
        add_pri_d      = add_pri_q;
        add_valid_d    = 1'b0;
        rm_id_d        = rm_id_q;
        rm_valid_d     = 1'b0;
        if (accept_s) begin
            res_valid_d = 1'b1;
            case (cmd_op)
                OP_SIG: begin
                    if (has_waiter_s) begin
                        rm_id_d        = que_top_id_s;
                        rm_valid_d     = 1'b1;
                        wakeup_id_d    = que_top_id_s;
                        wakeup_valid_d = 1'b1;
                        res_code_d     = E_OK;
                        state_d        = ST_SETTLE;
                    end else if (semcnt_q < MAX_CNT) begin
                        semcnt_d   = semcnt_q + SEM_ONE;
                        res_code_d = E_OK;
                    end else begin
                        res_code_d = E_QOVR;
                    end
                end
                OP_WAI: begin
                    if (semcnt_q != SEM_ZERO) begin
                        semcnt_d   = semcnt_q - SEM_ONE;
                        res_code_d = E_OK;
                    end else if (que_count_s < QUE_FULL) begin
                        add_id_d    = cmd_id;
                        add_pri_d   = cmd_pri;
                        add_valid_d = 1'b1;
                        res_code_d  = E_WAIT;
                        state_d     = ST_SETTLE;
                    end else begin
                        res_code_d = E_QOVR;
                    end
                end
                OP_POL: begin
                    if (semcnt_q != SEM_ZERO) begin
                        semcnt_d   = semcnt_q - SEM_ONE;
                        res_code_d = E_OK;
                    end else begin
                        res_code_d = E_TMOUT;
                    end
                end
                OP_CAN: begin
                    rm_id_d    = cmd_id;
                    rm_valid_d = 1'b1;
                    res_code_d = E_OK;
                    state_d    = ST_SETTLE;
                end
                default: begin
                    res_code_d = E_OK;
                end
            endcase
        end else begin
            res_valid_d = 1'b0;
        end
    end

    // Control FSM and registered outputs, frozen while cke is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            semcnt_q       <= INIT_CNT;
            res_code_q     <= E_OK;
            res_valid_q    <= 1'b0;
            wakeup_id_q    <= {ID_WIDTH{1'b0}};
            wakeup_valid_q <= 1'b0;
            add_id_q       <= {ID_WIDTH{1'b0}};
            add_pri_q      <= {PRI_WIDTH{1'b0}};
            add_valid_q    <= 1'b0;
            rm_id_q        <= {ID_WIDTH{1'b0}};
            rm_valid_q     <= 1'b0;
        end else if (cke) begin
            state_q        <= state_d;
            semcnt_q       <= semcnt_d;
            res_code_q     <= res_code_d;
            res_valid_q    <= res_valid_d;
            wakeup_id_q    <= wakeup_id_d;
            wakeup_valid_q <= wakeup_valid_d;
            add_id_q       <= add_id_d;
            add_pri_q      <= add_pri_d;
            add_valid_q    <= add_valid_d;
            rm_id_q        <= rm_id_d;
            rm_valid_q     <= rm_valid_d;
        end
    end

    jelly2_rtos_queue #(
        .PRIORITY_ORDER (PRIORITY_ORDER),
        .QUE_SIZE       (QUE_SIZE),
        .ID_WIDTH       (ID_WIDTH),
        .PRI_WIDTH      (PRI_WIDTH),
        .COUNT_WIDTH    (QUECNT_WIDTH)
    ) u_queue (
        .clk          (clk),
        .reset        (que_reset_s),
        .cke          (cke),
        .add_id       (add_id_q),
        .add_pri      (add_pri_q),
        .add_valid    (add_valid_q),
        .remove_id    (rm_id_q),
        .remove_valid (rm_valid_q),
        .top_id       (que_top_id_s),
        .top_valid    (que_top_valid_s),
        .count        (que_count_s)
    );

    assign cmd_ready    = (state_q == ST_IDLE);
    assign res_code     = res_code_q;
    assign res_valid    = res_valid_q;
    assign wakeup_id    = wakeup_id_q;
    assign wakeup_valid = wakeup_valid_q;
    assign semcnt       = semcnt_q;
    assign wait_count   = que_count_s;

endmodule
